// File: rtl/shift_pkg.sv
// Types and constants shared by the 4-bit shift operator and its nibble_serializer.
package shift_pkg;

    localparam int SHIFT_W = 4;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/nibble_fifo.sv
// Two-entry synchronous FIFO. rdata always shows the head entry; push is ignored when full, pop when empty.
module nibble_fifo #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
        end
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/nibble_serializer.sv
// Serializes each accepted WIDTH-bit word onto a valid/ready bit link; a 2-entry FIFO plus
// a bypass path into the shifter lets consecutive words stream with no idle cycle.
module nibble_serializer
    import shift_pkg::*;
#(
    parameter int WIDTH     = SHIFT_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    input  logic             ser_ready
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;

    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             accept, xfer;

    // in_ready depends only on the FIFO's registered count, never on ser_ready.
    assign in_ready  = !fifo_full;
    assign accept    = in_valid && in_ready;
    assign ser_valid = (state_q == SER_SHIFT);
    assign ser_last  = ser_valid && (bit_cnt_q == LAST_CNT);
    assign ser_out   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign xfer      = ser_valid && ser_ready;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        fifo_pop  = 1'b0;
        fifo_push = accept;
        case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_rdata;
                    bit_cnt_d = '0;
                    state_d   = SER_SHIFT;
                end else if (accept) begin
                    fifo_push = 1'b0;
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    state_d   = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (xfer && ser_last) begin
                    // Word boundary: reload from the buffer head first, else bypass the incoming word.
                    bit_cnt_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                    end else if (accept) begin
                        fifo_push = 1'b0;
                        shreg_d   = in_data;
                    end else begin
                        state_d = SER_IDLE;
                    end
                end else if (xfer) begin
                    shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SER_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    nibble_fifo #(
        .W(WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: one MSB-first and one LSB-first instance share the same stimulus
// and are checked every cycle against a word-queue model of the link.
module tb_nibble_serializer;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         ser_ready;

    logic in_ready_m, ser_out_m, ser_valid_m, ser_last_m;
    logic in_ready_l, ser_out_l, ser_valid_l, ser_last_l;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int   cyc;
        logic b;
        logic last;
    } log_t;

    log_t         log_m[$];
    log_t         log_l[$];
    int           acc_log[$];
    logic [W-1:0] exp_q[$];
    int           bitpos = 0;

    nibble_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_m),
        .ser_out   (ser_out_m),
        .ser_valid (ser_valid_m),
        .ser_last  (ser_last_m),
        .ser_ready (ser_ready)
    );

    nibble_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_l),
        .ser_out   (ser_out_l),
        .ser_valid (ser_valid_l),
        .ser_last  (ser_last_l),
        .ser_ready (ser_ready)
    );

    // Clock and reset-independent cycle stamp.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the word at the head of exp_q is the one on the link; bitpos is its next bit.
    logic         m_valid, m_ready, m_acc, m_xfer;
    logic [W-1:0] m_word;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst in_ready_m", 32'(in_ready_m), 32'd1);
            check("rst ser_valid_m", 32'(ser_valid_m), 32'd0);
            check("rst ser_last_m", 32'(ser_last_m), 32'd0);
            check("rst ser_out_m", 32'(ser_out_m), 32'd0);
            check("rst in_ready_l", 32'(in_ready_l), 32'd1);
            check("rst ser_valid_l", 32'(ser_valid_l), 32'd0);
            check("rst ser_out_l", 32'(ser_out_l), 32'd0);
            exp_q.delete();
            bitpos = 0;
        end else begin
            m_valid = (exp_q.size() > 0);
            m_ready = (exp_q.size() < 3);
            check("ser_valid_m", 32'(ser_valid_m), 32'(m_valid));
            check("ser_valid_l", 32'(ser_valid_l), 32'(m_valid));
            check("in_ready_m", 32'(in_ready_m), 32'(m_ready));
            check("in_ready_l", 32'(in_ready_l), 32'(m_ready));
            if (m_valid) begin
                m_word = exp_q[0];
                check("ser_out_m", 32'(ser_out_m), 32'(m_word[W-1-bitpos]));
                check("ser_out_l", 32'(ser_out_l), 32'(m_word[bitpos]));
                check("ser_last_m", 32'(ser_last_m), 32'(bitpos == W-1));
                check("ser_last_l", 32'(ser_last_l), 32'(bitpos == W-1));
            end else begin
                check("idle ser_last_m", 32'(ser_last_m), 32'd0);
                check("idle ser_last_l", 32'(ser_last_l), 32'd0);
            end
            if (ser_valid_m && ser_ready) log_m.push_back('{cyc: cyc, b: ser_out_m, last: ser_last_m});
            if (ser_valid_l && ser_ready) log_l.push_back('{cyc: cyc, b: ser_out_l, last: ser_last_l});
            if (in_valid && in_ready_m) acc_log.push_back(cyc);
            m_xfer = m_valid && ser_ready;
            m_acc  = in_valid && m_ready;
            if (m_xfer) begin
                if (bitpos == W-1) begin
                    void'(exp_q.pop_front());
                    bitpos = 0;
                end else begin
                    bitpos++;
                end
            end
            if (m_acc) exp_q.push_back(in_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_m.delete();
        log_l.delete();
        acc_log.delete();
    endtask

    // Compares the transferred bit log of one instance with a hand-computed sequence (first bit = MSB of bits).
    task automatic check_log(input string name, input bit lsb, input logic [15:0] bits,
                             input logic [15:0] lasts, input int n);
        int   sz;
        log_t e;
        int   first;
        sz = lsb ? log_l.size() : log_m.size();
        check({name, " count"}, 32'(sz), 32'(n));
        first = 0;
        for (int i = 0; i < n && i < sz; i++) begin
            e = lsb ? log_l[i] : log_m[i];
            if (i == 0) first = e.cyc;
            check({name, " bit"}, 32'(e.b), 32'(bits[n-1-i]));
            check({name, " last"}, 32'(e.last), 32'(lasts[n-1-i]));
            check({name, " contiguous"}, 32'(e.cyc - first), 32'(i));
        end
    endtask

    initial begin
        logic [W-1:0] words [4];
        int           idx;
        logic         acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        ser_ready = 1'b1;
        repeat (3) tick();
        check("reset in_ready", 32'(in_ready_m), 32'd1);
        check("reset ser_valid", 32'(ser_valid_m), 32'd0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single word 4'hB.
        clear_logs();
        in_valid = 1'b1;
        in_data  = 4'hB;
        tick();
        in_valid = 1'b0;
        check("single first valid", 32'(ser_valid_m), 32'd1);
        check("single first bit", 32'(ser_out_m), 32'd1);
        repeat (6) tick();
        check_log("single msb", 1'b0, 16'b1011, 16'b0001, 4);
        check_log("single lsb", 1'b1, 16'b1101, 16'b0001, 4);
        check("single then idle", 32'(ser_valid_m), 32'd0);

        // Back-to-back stream A, 5, F.
        clear_logs();
        in_valid = 1'b1;
        in_data  = 4'hA;
        tick();
        in_data  = 4'h5;
        tick();
        in_data  = 4'hF;
        tick();
        in_valid = 1'b0;
        repeat (14) tick();
        check_log("stream msb", 1'b0, 16'b1010_0101_1111, 16'b0001_0001_0001, 12);
        check_log("stream lsb", 1'b1, 16'b0101_1010_1111, 16'b0001_0001_0001, 12);

        // Backpressure: 10 stalled cycles while 4 words are offered.
        clear_logs();
        words[0] = 4'h3;
        words[1] = 4'hC;
        words[2] = 4'h6;
        words[3] = 4'h9;
        idx = 0;
        for (int c = 0; c < 60 && idx < 4; c++) begin
            ser_ready = (c >= 10);
            in_valid  = 1'b1;
            in_data   = words[idx];
            @(negedge clk);
            acc = in_ready_m;
            tick();
            if (acc) idx++;
            if (c == 9) begin
                check("stall accepted words", 32'(idx), 32'd3);
                check("stall in_ready", 32'(in_ready_m), 32'd0);
            end
        end
        check("backpressure all accepted", 32'(idx), 32'd4);
        in_valid  = 1'b0;
        ser_ready = 1'b1;
        repeat (20) tick();
        check_log("bp msb", 1'b0, 16'b0011_1100_0110_1001, 16'b0001_0001_0001_0001, 16);
        check_log("bp lsb", 1'b1, 16'b1100_0011_0110_1001, 16'b0001_0001_0001_0001, 16);
        check("bp accept count", 32'(acc_log.size()), 32'd4);
        if (acc_log.size() == 4 && log_m.size() >= 4) begin
            check("full-buffer accept one edge after last bit", 32'(acc_log[3]), 32'(log_m[3].cyc + 1));
        end

        // LSB-first word 4'b0001.
        clear_logs();
        in_valid = 1'b1;
        in_data  = 4'b0001;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check_log("lsbmode lsb", 1'b1, 16'b1000, 16'b0001, 4);
        check_log("lsbmode msb", 1'b0, 16'b0001, 16'b0001, 4);

        // Reset mid-word after two bits of 4'b1011.
        clear_logs();
        in_valid = 1'b1;
        in_data  = 4'b1011;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        #1;
        check("midrst ser_valid", 32'(ser_valid_m), 32'd0);
        check("midrst ser_last", 32'(ser_last_m), 32'd0);
        check("midrst ser_out", 32'(ser_out_m), 32'd0);
        check("midrst in_ready", 32'(in_ready_m), 32'd1);
        check_log("midrst partial", 1'b0, 16'b10, 16'b00, 2);
        tick();
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post-rst in_ready", 32'(in_ready_m), 32'd1);
            check("post-rst ser_valid", 32'(ser_valid_m), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 4'h6;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check_log("post-rst msb", 1'b0, 16'b0110, 16'b0001, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nibble_serializer.md
# nibble_serializer

Downstream stage of the 4-bit shift operator: captures each shifted nibble it produces and sends it out one bit per clock over a serial link with flow control. A valid/ready input port backed by a 2-entry buffer absorbs results while a word is being shifted out. Back-to-back words stream with no idle cycle between them.

## Interface

Parameters:
- WIDTH, 4, word width in bits; must match the shift operator's data width.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  nibble from the shift operator (its data_out).
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  current serial bit.
- ser_valid  out  1  ser_out is valid.
- ser_last  out  1  ser_out is the final bit of its word.
- ser_ready  in  1  receiver accepts ser_out this cycle.

## Operation

- Input handshake: a word is accepted on a rising edge where in_valid && in_ready.
- in_ready = !buf_full. It is derived only from registered state and has no combinational path from ser_ready.
- Buffer: 2-entry FIFO of WIDTH-bit words, holding accepted words not yet loaded into the shifter.
- Shifter: WIDTH-bit shift register plus bit counter bit_cnt (clog2(WIDTH) bits).
- A serial bit transfers on a rising edge where ser_valid && ser_ready.
- FSM states:
  - IDLE: ser_valid = 0.
  - SHIFT: ser_valid = 1.
- IDLE transitions:
  - Buffer empty and a word is accepted: the word bypasses the FIFO, loads the shifter, bit_cnt = 0, next state SHIFT.
  - Buffer non-empty: pop the head into the shifter, go to SHIFT. This case cannot arise in normal operation; it is kept for robustness.
- SHIFT, on a non-last transfer: shift toward the output end, bit_cnt + 1.
- SHIFT, on a transfer with ser_last:
  - Buffer non-empty: pop the head into the shifter on the same edge, bit_cnt = 0, stay in SHIFT.
  - Buffer empty but a word is accepted on the same edge: that word bypasses into the shifter, stay in SHIFT.
  - Otherwise: go to IDLE.
- ser_out = shifter[WIDTH-1] when MSB_FIRST = 1, else shifter[0].
- ser_last = (state == SHIFT) && (bit_cnt == WIDTH-1).
- Stall: while ser_ready = 0 in SHIFT, ser_out, ser_last and bit_cnt hold. The buffer may keep filling until full.
- Simultaneous push and pop with the buffer not full: both happen and the count is unchanged; FIFO order is preserved.
- Full buffer with a pop on the same edge: no push that cycle, because in_ready was 0. The freed slot is visible the next cycle.
- Words are never dropped, reordered or duplicated.

## Timing

- Reset (rst_n low, asynchronous):
  - state = IDLE, buffer empty, shifter = 0, bit_cnt = 0.
  - ser_valid = 0, ser_last = 0, ser_out = 0, in_ready = 1.
- While rst_n is low, in_valid is ignored.
- A reset asserted mid-word discards the partial word and all buffered words. The first edge after release is a normal IDLE cycle.
- Latency: a word accepted on edge N (idle, empty buffer) presents its first bit in the cycle after N. Its last bit is accepted no earlier than edge N+WIDTH.
- Throughput: 1 bit/cycle sustained with ser_ready held high and in_valid supplied at least once per WIDTH cycles.
- Gap between consecutive words when a next word is available: zero cycles; ser_valid stays high across the boundary.
- Maximum occupancy: 1 word in the shifter + 2 in the buffer.

## Structure

- Shared package shift_pkg:
  - localparam SHIFT_W = 4, used by both the shift operator and this block.
  - typedef enum {SER_IDLE, SER_SHIFT} ser_state_t.
- Sub-module nibble_fifo: 2-entry synchronous FIFO.
  - Ports: clk, rst_n, push, pop, wdata, rdata, full, empty.
  - Implementation: 1-bit pointers plus a 2-bit count.
- The top level holds the FSM, shifter, bit counter and bypass mux.

## Test plan

- Reset check: assert rst_n = 0 mid-word (after 2 bits of 4'b1011) -> outputs go to reset values immediately; after release, in_ready = 1 and ser_valid = 0 until the next accept.
- Single word: send 4'hB, MSB_FIRST = 1, ser_ready = 1 -> ser_out sequence 1,0,1,1 on 4 consecutive cycles, ser_last only on the 4th, then ser_valid = 0.
- Streaming: send 4'hA, 4'h5, 4'hF back-to-back, ser_ready = 1 -> 12 contiguous valid bits 1010_0101_1111, ser_last every 4th bit, no gap.
- Backpressure: ser_ready = 0 for 10 cycles while 4 words are offered -> in_ready drops after 3 accepted words (1 shifter + 2 buffer), ser_out holds, and the words emerge in order once ser_ready returns.
- Boundary simultaneity: buffer full, last bit transfers on the same edge as in_valid -> no accept that edge; accept on the next edge; no loss or duplication.
- LSB-first mode: MSB_FIRST = 0, send 4'b0001 -> sequence 1,0,0,0 with ser_last on the 4th bit.
